uart_tx_serializer: RTL

//  Serializes the 8-bit byte that the memory-mapped IO block presents on its UART tx output into an

---
 rtl/uart_tx_serializer_if.sv | 11 +
 rtl/uart_tx_serializer.sv | 127 ++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer_if.sv
// Byte-in / serial-out handshake between the IO block (master) and the UART serializer (slave).
interface uart_tx_serializer_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  modport master (output tx_data, tx_start, input tx, tx_busy, tx_done);
  modport slave  (input tx_data, tx_start, output tx, tx_busy, tx_done);
endinterface

// File: rtl/uart_tx_serializer.sv
// UART tx: start, 8 data LSB first, [even parity if UART_TX_PARITY_EN], STOP_BITS stop; all outputs registered.
// Frame begins on the edge tx_start is seen while idle; tx_start is ignored while busy, no queueing.
module uart_tx_serializer #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned STOP_BITS    = 1
) (
  input logic                 clk,
  input logic                 rst,
  uart_tx_serializer_if.slave tx_if
);

  localparam int unsigned   BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic          stop_q, stop_d;
  logic [7:0]    data_q, data_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          baud_tc;

  assign baud_tc = (baud_q == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      data_q  <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      data_q  <= data_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    data_d  = data_q;
    if (state_q == S_IDLE) begin
      baud_d = '0;
      if (tx_if.tx_start) begin
        state_d = S_START;
        data_d  = tx_if.tx_data;
        bit_d   = 3'd0;
        stop_d  = 1'b0;
      end
    end else begin
      baud_d = baud_tc ? '0 : baud_q + BW'(1);
      case (state_q)
        S_START: if (baud_tc) state_d = S_DATA;
        S_DATA: begin
          if (baud_tc) begin
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: if (baud_tc) state_d = S_STOP;
`endif
        S_STOP: begin
          if (baud_tc) begin
            if (stop_q == STOP_LAST) begin
              state_d = S_IDLE;
              stop_d  = 1'b0;
            end else begin
              stop_d = 1'b1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs are the registered image of the state being entered, so the line changes on the FSM edge.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_d != S_IDLE);
    done_d = (state_q == S_STOP) && (state_d == S_IDLE);
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = data_q[bit_d];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = ^data_q;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  assign tx_if.tx      = tx_q;
  assign tx_if.tx_busy = busy_q;
  assign tx_if.tx_done = done_q;

endmodule
